// File: rtl/gen_clk_div_pkg.sv
// Shared definitions for the power-of-two clock divider: FSM state type
// and the legal ranges of the divider parameters.
// Latency: n/a (types and constants only). Backpressure: n/a.
package gen_clk_div_pkg;

  // Divider control states; 2-bit encoding, value 3 unused.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BASE_LOG2_MIN = 1;
  localparam int BASE_LOG2_MAX = 8;
  localparam int NUM_OUT_MIN   = 1;
  localparam int NUM_OUT_MAX   = 8;

endpackage

// File: rtl/gen_clk_div.sv
// Phase-aligned power-of-two clock divider: output i = clk_8f / 2^(BASE_LOG2+i),
// started/stopped cleanly (no runt phases), with rise strobes and a lock flag.
// Latency: every output is a flop; strobes coincide with their clock's rising edge.
// Backpressure: none; enable low lets the counter drain to zero before idling.
//
// Ports:
//   clk_8f   - source clock, all logic on its rising edge
//   reset    - asynchronous active-high reset
//   enable   - request divided clocks to run
//   sync_clr - synchronous phase realignment (counter back to zero)
//   clk_div  - divided clocks, bit i half the frequency of bit i-1
//   rise_stb - one-cycle strobe per output, high while clk_div[i] has just risen
//   active   - high in RUN or DRAIN
//   locked   - high once the slowest output has risen since leaving IDLE
module gen_clk_div
  import gen_clk_div_pkg::*;
#(
  parameter int BASE_LOG2 = 2,
  parameter int NUM_OUT   = 2
) (
  input  logic               clk_8f,
  input  logic               reset,
  input  logic               enable,
  input  logic               sync_clr,
  output logic [NUM_OUT-1:0] clk_div,
  output logic [NUM_OUT-1:0] rise_stb,
  output logic               active,
  output logic               locked
);

  localparam int CW = BASE_LOG2 + NUM_OUT - 1;

  if (BASE_LOG2 < BASE_LOG2_MIN || BASE_LOG2 > BASE_LOG2_MAX) begin : g_bad_base_log2
    $error("gen_clk_div: BASE_LOG2 out of range");
  end
  if (NUM_OUT < NUM_OUT_MIN || NUM_OUT > NUM_OUT_MAX) begin : g_bad_num_out
    $error("gen_clk_div: NUM_OUT out of range");
  end

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n, cnt_inc;
  logic               cnt_wrap;
  logic [NUM_OUT-1:0] rise_n;
  logic               locked_n;

  always_comb begin
    cnt_inc  = cnt + CW'(1);
    cnt_wrap = (cnt_inc == '0);
    state_n  = state;
    cnt_n    = cnt;

    if (sync_clr) begin
      // Realign phase: a running divider keeps running from zero.
      cnt_n   = '0;
      state_n = (state == RUN) ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n = '0;
          if (enable) state_n = RUN;
        end
        RUN: begin
          if (enable) begin
            cnt_n = cnt_inc;
          end else if (cnt == '0) begin
            // Already at the common low point: stop without draining.
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = DRAIN;
            cnt_n   = cnt_inc;
          end
        end
        DRAIN: begin
          if (enable) begin
            state_n = RUN;
            cnt_n   = cnt_inc;
          end else if (cnt_wrap) begin
            // Every output has just completed its low phase together.
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // Strobe flags a 0->1 transition of each output bit into the next cycle.
    rise_n = cnt_n[CW-1 -: NUM_OUT] & ~cnt[CW-1 -: NUM_OUT];
    if (sync_clr || state_n == IDLE) rise_n = '0;

    if (sync_clr || state_n == IDLE) begin
      locked_n = 1'b0;
    end else if (rise_n[NUM_OUT-1]) begin
      locked_n = 1'b1;
    end else begin
      locked_n = locked;
    end
  end

  // Counter, FSM state, strobes and lock share one register process.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rise_stb <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rise_stb <= rise_n;
      locked   <= locked_n;
    end
  end

  assign clk_div = cnt[CW-1 -: NUM_OUT];
  assign active  = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_gen_clk_div.sv
module tb_gen_clk_div;

  logic       clk = 1'b0;
  logic       rst, en, sc;
  logic [1:0] div_a, rise_a;
  logic [3:0] div_b, rise_b;
  logic       act_a, lock_a, act_b, lock_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gen_clk_div #(.BASE_LOG2(2), .NUM_OUT(2)) u_a (
    .clk_8f(clk), .reset(rst), .enable(en), .sync_clr(sc),
    .clk_div(div_a), .rise_stb(rise_a), .active(act_a), .locked(lock_a)
  );

  gen_clk_div #(.BASE_LOG2(1), .NUM_OUT(4)) u_b (
    .clk_8f(clk), .reset(rst), .enable(en), .sync_clr(sc),
    .clk_div(div_b), .rise_stb(rise_b), .active(act_b), .locked(lock_b)
  );

  // Reference model: phase position p within the full pattern period, plus a
  // mode (0 idle, 1 run, 2 drain). Output i is the arithmetic bit of p.
  int mb[2];
  int mn[2];
  int m_mode[2];
  int m_p[2];
  int m_lock[2];
  int m_rise[2];
  int since_run[2];
  int last_rise[2][8];
  int cyc_no = 0;
  bit per_en = 1'b0;

  function automatic int bitof(int k, int x, int i);
    return (x / (1 << (mb[k] - 1 + i))) % 2;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, int expv);
    n_assert++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_p[k] = 0; m_lock[k] = 0; m_rise[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int period, old, prev_mode;
      period    = 1 << (mb[k] + mn[k] - 1);
      old       = m_p[k];
      prev_mode = m_mode[k];
      if (rst) begin
        m_mode[k] = 0; m_p[k] = 0; m_lock[k] = 0; m_rise[k] = 0;
      end else if (sc) begin
        m_p[k] = 0;
        if (m_mode[k] != 1) m_mode[k] = 0;
        m_rise[k] = 0;
        m_lock[k] = 0;
      end else begin
        case (m_mode[k])
          0: begin m_p[k] = 0; if (en) m_mode[k] = 1; end
          1: begin
            if (en) m_p[k] = (old + 1) % period;
            else if (old == 0) m_mode[k] = 0;
            else begin m_mode[k] = 2; m_p[k] = (old + 1) % period; end
          end
          default: begin
            if (en) begin m_mode[k] = 1; m_p[k] = (old + 1) % period; end
            else if ((old + 1) % period == 0) begin m_mode[k] = 0; m_p[k] = 0; end
            else m_p[k] = old + 1;
          end
        endcase
        m_rise[k] = 0;
        for (int i = 0; i < mn[k]; i++)
          if (bitof(k, m_p[k], i) == 1 && bitof(k, old, i) == 0) m_rise[k] |= (1 << i);
        if (m_mode[k] == 0) m_lock[k] = 0;
        else if (((m_rise[k] >> (mn[k] - 1)) & 1) == 1) m_lock[k] = 1;
      end
      if (prev_mode == 0 && m_mode[k] == 1) since_run[k] = 0;
      else since_run[k]++;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int ed;
      logic [31:0] o_div, o_rise, o_act, o_lock;
      ed = 0;
      for (int i = 0; i < mn[k]; i++) ed |= bitof(k, m_p[k], i) << i;
      o_div  = (k == 0) ? 32'(div_a)  : 32'(div_b);
      o_rise = (k == 0) ? 32'(rise_a) : 32'(rise_b);
      o_act  = (k == 0) ? 32'(act_a)  : 32'(act_b);
      o_lock = (k == 0) ? 32'(lock_a) : 32'(lock_b);
      chk($sformatf("inst%0d.clk_div cyc%0d", k, cyc_no), o_div, ed);
      chk($sformatf("inst%0d.rise_stb cyc%0d", k, cyc_no), o_rise, m_rise[k]);
      chk($sformatf("inst%0d.active cyc%0d", k, cyc_no), o_act, (m_mode[k] != 0) ? 1 : 0);
      chk($sformatf("inst%0d.locked cyc%0d", k, cyc_no), o_lock, m_lock[k]);
      for (int i = 0; i < mn[k]; i++) begin
        if (o_rise[i]) begin
          if (per_en && last_rise[k][i] >= 0)
            chk($sformatf("inst%0d.period%0d", k, i), 32'(cyc_no - last_rise[k][i]),
                1 << (mb[k] + i));
          last_rise[k][i] = cyc_no;
        end
      end
    end
  endtask

  task automatic clear_periods();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) last_rise[k][i] = -1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
    check_all();
  endtask

  task automatic wait_p(int k, int target);
    int g;
    g = 0;
    while (m_p[k] != target && g < 40) begin
      cyc();
      g++;
    end
    chk($sformatf("wait_p%0d_bound", target), 32'((g < 40) ? 1 : 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, la, lb, dcnt;
    mb[0] = 2; mn[0] = 2;
    mb[1] = 1; mn[1] = 4;
    since_run[0] = 0; since_run[1] = 0;
    clear_periods();
    model_reset();
    rst = 1'b1; en = 1'b0; sc = 1'b0;

    // Reset state, then idle with enable low: nothing may toggle.
    #3;
    check_all();
    cyc(); cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Start-up latencies from entering RUN.
    en = 1'b1;
    ra = -1; la = -1; lb = -1;
    for (int j = 0; j < 12; j++) begin
      cyc();
      if (ra < 0 && rise_a[0]) ra = since_run[0];
      if (la < 0 && lock_a) la = since_run[0];
      if (lb < 0 && lock_b) lb = since_run[1];
    end
    chk("first_rise_a0", 32'(ra), 2);
    chk("lock_latency_a", 32'(la), 4);
    chk("lock_latency_b", 32'(lb), 8);

    // Steady-state periods.
    clear_periods();
    per_en = 1'b1;
    repeat (40) cyc();
    per_en = 1'b0;

    // Drop enable at count 3: inst0 drains 4 cycles then idles.
    wait_p(0, 3);
    en = 1'b0;
    dcnt = 0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      if (act_a) dcnt++;
    end
    chk("drain_len_a", 32'(dcnt), 4);
    chk("drain_end_div_a", 32'(div_a), 0);
    repeat (8) cyc();

    // Drop then re-raise enable while draining: no phase jump.
    en = 1'b1;
    repeat (6) cyc();
    en = 1'b0;
    repeat (2) cyc();
    chk("in_drain_a", 32'(act_a), 1);
    en = 1'b1;
    clear_periods();
    per_en = 1'b1;
    repeat (24) cyc();
    per_en = 1'b0;

    // Phase realignment at count 5.
    wait_p(0, 5);
    sc = 1'b1;
    cyc();
    sc = 1'b0;
    chk("sync_clr_div_a", 32'(div_a), 0);
    chk("sync_clr_lock_a", 32'(lock_a), 0);
    chk("sync_clr_div_b", 32'(div_b), 0);
    clear_periods();
    per_en = 1'b1;
    repeat (20) cyc();
    per_en = 1'b0;

    // Random enable / realignment traffic against the model.
    for (int j = 0; j < 400; j++) begin
      en = ($urandom_range(0, 9) < 7);
      sc = ($urandom_range(0, 29) == 0);
      cyc();
    end

    // Asynchronous reset mid-period.
    sc = 1'b0; en = 1'b1;
    repeat (7) cyc();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_div_a", 32'(div_a), 0);
    chk("arst_rise_a", 32'(rise_a), 0);
    chk("arst_act_a", 32'(act_a), 0);
    chk("arst_lock_a", 32'(lock_a), 0);
    chk("arst_div_b", 32'(div_b), 0);
    chk("arst_lock_b", 32'(lock_b), 0);
    cyc(); cyc();
    rst = 1'b0;
    en = 1'b0;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_clk_div.md
GEN_CLK_DIV -- requirements
Module: gen_clk_div

Interface
REQ-001 The block SHALL have parameter BASE_LOG2, default 2, meaning log2 of the divide ratio of output 0 (legal 1..8).
REQ-002 The block SHALL have parameter NUM_OUT, default 2, meaning the number of divided clocks; output i divides clk_8f by 2^(BASE_LOG2+i) (legal 1..8).
REQ-003 The block SHALL have port clk_8f, input, 1 bit: the single source clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: request divided clocks to run.
REQ-006 The block SHALL have port sync_clr, input, 1 bit: synchronous phase realignment.
REQ-007 The block SHALL have port clk_div, output, NUM_OUT bits: divided clocks, bit i slower than bit i-1 by 2x.
REQ-008 The block SHALL have port rise_stb, output, NUM_OUT bits: one-cycle strobe, bit i high in the clk_8f cycle in which clk_div[i] has just gone 0->1.
REQ-009 The block SHALL have port active, output, 1 bit: high when the state is RUN or DRAIN.
REQ-010 The block SHALL have port locked, output, 1 bit: high once clk_div[NUM_OUT-1] has completed its first rising edge since leaving IDLE.

Function
REQ-011 The block SHALL contain a CW = BASE_LOG2+NUM_OUT-1 bit counter cnt; clk_div[i] SHALL equal cnt[BASE_LOG2-1+i], with every output a flop with no combinational path from inputs.
REQ-012 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-013 In IDLE: cnt held at 0; if enable=1, the next state SHALL be RUN with cnt still 0.
REQ-014 In RUN: cnt SHALL increment by 1 every edge, wrapping modulo 2^CW.
REQ-015 In RUN with enable=0: if cnt==0, the next state SHALL be IDLE; otherwise DRAIN, with cnt still incrementing.
REQ-016 In DRAIN: cnt SHALL increment; when cnt+1 wraps to 0, the next state SHALL be IDLE with cnt=0, so no output is ever truncated (no runt high or low phase).
REQ-017 In DRAIN with enable=1: the next state SHALL be RUN, with the count undisturbed.
REQ-018 rise_stb[i] SHALL be registered from the next-state value, equal to (next cnt bit BASE_LOG2-1+i ==1) AND (current bit ==0); it SHALL be all-zero in IDLE.
REQ-019 sync_clr=1 SHALL, at the next edge, set cnt=0, rise_stb=0 and locked=0; RUN stays RUN, and DRAIN and IDLE go to IDLE.
REQ-020 Priority SHALL be reset > sync_clr > enable logic.
REQ-021 locked SHALL set on the edge that sets rise_stb[NUM_OUT-1], and SHALL clear on entering IDLE or on sync_clr.
REQ-022 Steady-state RUN output i SHALL have period 2^(BASE_LOG2+i) clk_8f cycles and 50% duty, and all outputs SHALL be low together when cnt==0 (phase-aligned).

Reset
REQ-023 While reset=1, the block SHALL asynchronously force state=IDLE, cnt=0, clk_div=0, rise_stb=0, active=0 and locked=0.
REQ-024 When reset is asserted mid-RUN or mid-DRAIN, the block SHALL take the values of REQ-023 immediately, with no drain.
REQ-025 After reset deasserts, the block SHALL require enable=1 sampled in IDLE before any output toggles.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE/RUN/DRAIN, 2-bit encoding) and the legal-range limits for BASE_LOG2 and NUM_OUT.
REQ-027 The block SHALL be a single module with no sub-modules; the counter and FSM SHALL share one always block per clock domain.
REQ-028 The block SHALL flag an elaboration-time error if a parameter is out of range.

Verification
REQ-029 Scenario, BASE_LOG2=2, NUM_OUT=2, enable held 1: clk_div[0] SHALL have period 4 and clk_div[1] period 8; the first rise_stb[0] SHALL come 2 cycles after entering RUN, and locked SHALL rise 4 cycles after entering RUN.
REQ-030 Scenario, enable dropped at cnt=3 (CW=3): state DRAIN SHALL hold for 4 cycles to reach cnt=0, then IDLE; clk_div SHALL end at 00 with no pulse shorter than 2 cycles.
REQ-031 Scenario, enable dropped then re-raised within DRAIN: the state SHALL return to RUN and the output periods SHALL be unchanged with no phase jump.
REQ-032 Scenario, sync_clr pulsed at cnt=5: the next cycle SHALL have cnt=0, clk_div=00 and locked=0, and the period sequence SHALL restart from that point.
REQ-033 Scenario, reset asserted asynchronously mid-period: all outputs SHALL go to 0 before the next clk_8f edge; after release, with enable=0, the outputs SHALL stay 0.
REQ-034 Scenario, BASE_LOG2=1, NUM_OUT=4: the clk_div periods SHALL be 2/4/8/16, each rise_stb[i] SHALL occur once per period, and locked SHALL rise 8 cycles after entering RUN.
